npu_act_mem_wr_arbiter: RTL and testbench

- Responder side of the neuron activation write handshake.
- Each neuron holds hw_mem_wr with its addr/data latched until it receives hw_mem_wr_ack_p. This block arbitrates round-robin among NUM_NEURONS requesters, drives one registered write per grant into the activation RAM, and returns a single-cycle ack to the granted neuron.
- It sits between the neuron array and the activation memory port. It also keeps a write counter and a sticky address-range error flag for layer sequencing and debug.

---
 rtl/npu_act_mem_wr_arbiter_pkg.sv | 24 ++
 rtl/npu_act_mem_wr_arbiter_if.sv | 44 ++++
 rtl/npu_rr_arbiter.sv | 30 +++
 rtl/npu_act_mem_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_npu_act_mem_wr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_act_mem_wr_arbiter_pkg.sv
// Shared constants and types for the activation memory write arbiter.
// Holds the default activation address width, the write counter width, the
// FSM state encodings and a saturating-increment helper.
package npu_act_mem_wr_arbiter_pkg;

  localparam int unsigned LOG2_ACT_ADDR_WIDTH = 10;
  localparam int unsigned ACT_WR_CNT_WIDTH    = 16;

  localparam logic ACT_WR_IDLE  = 1'b0;
  localparam logic ACT_WR_WRITE = 1'b1;

  typedef enum logic [0:0] {
    StIdle  = ACT_WR_IDLE,
    StWrite = ACT_WR_WRITE
  } act_wr_state_e;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [ACT_WR_CNT_WIDTH-1:0] sat_inc(
    input logic [ACT_WR_CNT_WIDTH-1:0] val
  );
    return (val == '1) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/npu_act_mem_wr_arbiter_if.sv
// Neuron write handshake plus activation RAM write port.
//   hw_mem_wr       : per-neuron level request, held until ack
//   hw_mem_wr_addr  : packed addresses, neuron i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   hw_mem_wr_data  : packed data, same slicing
//   hw_mem_wr_ack_p : one-hot single-cycle ack back to the granted neuron
//   act_mem_*       : registered write port into the activation RAM
// Modports: master = neuron array / RAM side, slave = arbiter.
interface npu_act_mem_wr_arbiter_if
  import npu_act_mem_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = LOG2_ACT_ADDR_WIDTH
) ();

  logic [NUM_NEURONS-1:0]            hw_mem_wr;
  logic [NUM_NEURONS*ADDR_WIDTH-1:0] hw_mem_wr_addr;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] hw_mem_wr_data;
  logic [NUM_NEURONS-1:0]            hw_mem_wr_ack_p;
  logic                              act_mem_we;
  logic [ADDR_WIDTH-1:0]             act_mem_addr;
  logic [DATA_WIDTH-1:0]             act_mem_wdata;

  modport master (
    output hw_mem_wr,
    output hw_mem_wr_addr,
    output hw_mem_wr_data,
    input  hw_mem_wr_ack_p,
    input  act_mem_we,
    input  act_mem_addr,
    input  act_mem_wdata
  );

  modport slave (
    input  hw_mem_wr,
    input  hw_mem_wr_addr,
    input  hw_mem_wr_data,
    output hw_mem_wr_ack_p,
    output act_mem_we,
    output act_mem_addr,
    output act_mem_wdata
  );

endinterface

// File: rtl/npu_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, searching
// circularly over NumReq requesters.
//   req_i         : request vector
//   ptr_i         : search start index (< NumReq)
//   grant_valid_o : some request is set
//   grant_idx_o   : index of the chosen requester (0 when none)
module npu_rr_arbiter #(
  parameter int unsigned NumReq = 8,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              grant_valid_o,
  output logic [IdxW-1:0]   grant_idx_o
);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      logic [IdxW-1:0] cand;
      cand = IdxW'((32'(ptr_i) + k) % NumReq);
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/npu_act_mem_wr_arbiter.sv
// Round-robin responder for neuron activation writes. One grant every two
// cycles at most: IDLE picks and latches a requester, WRITE drives the RAM
// and acks. The idle cycle after each ack lets the acked neuron drop its
// request before the next pick, so a write can never be issued twice.
//   clk, rst     : clock, asynchronous active-low reset
//   bus          : neuron handshake + activation RAM port (slave modport)
//   hold_i       : block new grants (sampled only in IDLE)
//   cnt_clr_i    : synchronous clear of wr_count_o and range_err_o
//   wr_count_o   : saturating count of writes actually issued
//   range_err_o  : sticky flag, a granted address was >= MEM_DEPTH
//   busy_o       : in WRITE or any request pending
module npu_act_mem_wr_arbiter
  import npu_act_mem_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = LOG2_ACT_ADDR_WIDTH,
  parameter int unsigned MEM_DEPTH   = 2 ** ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  npu_act_mem_wr_arbiter_if.slave     bus,
  input  logic                        hold_i,
  input  logic                        cnt_clr_i,
  output logic [ACT_WR_CNT_WIDTH-1:0] wr_count_o,
  output logic                        range_err_o,
  output logic                        busy_o
);

  localparam int unsigned IdxW = $clog2(NUM_NEURONS);

  act_wr_state_e               state_q, state_d;
  logic [IdxW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic                        we_q, we_d;
  logic [NUM_NEURONS-1:0]      ack_q, ack_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [ACT_WR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                        rerr_q, rerr_d;

  logic                        grant_valid;
  logic [IdxW-1:0]             grant_idx;
  logic [ADDR_WIDTH-1:0]       sel_addr;
  logic [DATA_WIDTH-1:0]       sel_data;
  logic                        sel_in_range;

  npu_rr_arbiter #(
    .NumReq (NUM_NEURONS),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req_i         (bus.hw_mem_wr),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Constant-slice mux keeps data of non-granted neurons (possibly X) out.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      if (grant_idx == IdxW'(i)) begin
        sel_addr = bus.hw_mem_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = bus.hw_mem_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Always true when MEM_DEPTH covers the whole address space.
  assign sel_in_range = 32'(sel_addr) < MEM_DEPTH;

  // we/ack/addr/data are loaded on the IDLE->WRITE transition so they are
  // registered and visible exactly during the WRITE cycle.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    ack_d    = '0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rerr_d   = rerr_q;

    unique case (state_q)
      StIdle: begin
        if (!hold_i && grant_valid) begin
          state_d          = StWrite;
          idx_d            = grant_idx;
          addr_d           = sel_addr;
          wdata_d          = sel_data;
          ack_d[grant_idx] = 1'b1;
          if (sel_in_range) begin
            we_d  = 1'b1;
            cnt_d = sat_inc(cnt_q);
          end else begin
            // Ack anyway so the neuron does not stall; only the write is dropped.
            rerr_d = 1'b1;
          end
        end
      end
      StWrite: begin
        state_d  = StIdle;
        rr_ptr_d = (idx_q == IdxW'(NUM_NEURONS - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (cnt_clr_i) begin
      cnt_d  = '0;
      rerr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      ack_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rerr_q   <= rerr_d;
    end
  end

  assign bus.act_mem_we      = we_q;
  assign bus.act_mem_addr    = addr_q;
  assign bus.act_mem_wdata   = wdata_q;
  assign bus.hw_mem_wr_ack_p = ack_q;
  assign wr_count_o          = cnt_q;
  assign range_err_o         = rerr_q;
  assign busy_o              = (state_q == StWrite) | (|bus.hw_mem_wr);

endmodule

// File: tb/tb_npu_act_mem_wr_arbiter.sv
// Bench for npu_act_mem_wr_arbiter: a table of per-cycle vectors followed by
// hand-written multi-cycle sequences (all-request sweep, fairness, hold,
// range error, reset during WRITE). DUT built with MEM_DEPTH=100.
module tb_npu_act_mem_wr_arbiter;

  localparam int unsigned NN = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        cnt_clr;
  logic [15:0] wr_count;
  logic        range_err;
  logic        busy;

  int n_checks;
  int n_fails;

  npu_act_mem_wr_arbiter_if #(
    .NUM_NEURONS (NN),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW)
  ) bus ();

  npu_act_mem_wr_arbiter #(
    .NUM_NEURONS (NN),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .MEM_DEPTH   (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .hold_i      (hold),
    .cnt_clr_i   (cnt_clr),
    .wr_count_o  (wr_count),
    .range_err_o (range_err),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  req;
    logic        hold;
    logic        clr;
    logic [7:0]  ack;
    logic        we;
    logic [9:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] cnt;
    logic        busy;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  logic [7:0] mem [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Neuron i: addr = 4*i+4, data = 0x57+i (neuron 3 -> 0x010 / 0x5A).
  task automatic set_neuron_payloads();
    for (int i = 0; i < NN; i++) begin
      bus.hw_mem_wr_addr[i*AW +: AW] = 10'(i * 4 + 4);
      bus.hw_mem_wr_data[i*DW +: DW] = 8'(8'h57 + i);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.hw_mem_wr = '0;
    hold          = 1'b0;
    cnt_clr       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    rst           = 1'b1;
    hold          = 1'b0;
    cnt_clr       = 1'b0;
    bus.hw_mem_wr = '0;
    set_neuron_payloads();

    // Reset values
    #2 rst = 1'b0;
    #2;
    check("rst_ack", 32'(bus.hw_mem_wr_ack_p), 32'h0);
    check("rst_we", 32'(bus.act_mem_we), 32'h0);
    check("rst_addr", 32'(bus.act_mem_addr), 32'h0);
    check("rst_wdata", 32'(bus.act_mem_wdata), 32'h0);
    check("rst_cnt", 32'(wr_count), 32'h0);
    check("rst_rerr", 32'(range_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Per-cycle vectors, starting from rr_ptr=0
    //            req    hold  clr   ack    we    addr   wdata  cnt    busy
    vecs[0]  = '{8'h08, 1'b0, 1'b0, 8'h08, 1'b1, 10'd16, 8'h5A, 16'd1, 1'b1};
    vecs[1]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 10'd16, 8'h5A, 16'd1, 1'b0};
    vecs[2]  = '{8'h03, 1'b1, 1'b0, 8'h00, 1'b0, 10'd16, 8'h5A, 16'd1, 1'b1};
    vecs[3]  = '{8'h03, 1'b1, 1'b0, 8'h00, 1'b0, 10'd16, 8'h5A, 16'd1, 1'b1};
    vecs[4]  = '{8'h03, 1'b0, 1'b0, 8'h01, 1'b1, 10'd4,  8'h57, 16'd2, 1'b1};
    vecs[5]  = '{8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 10'd4,  8'h57, 16'd2, 1'b1};
    vecs[6]  = '{8'h02, 1'b0, 1'b0, 8'h02, 1'b1, 10'd8,  8'h58, 16'd3, 1'b1};
    vecs[7]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 10'd8,  8'h58, 16'd3, 1'b0};
    vecs[8]  = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 10'd8,  8'h58, 16'd0, 1'b0};
    vecs[9]  = '{8'h20, 1'b0, 1'b1, 8'h20, 1'b1, 10'd24, 8'h5C, 16'd0, 1'b1};
    vecs[10] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 10'd24, 8'h5C, 16'd0, 1'b0};
    vecs[11] = '{8'h41, 1'b0, 1'b0, 8'h40, 1'b1, 10'd28, 8'h5D, 16'd1, 1'b1};
    vecs[12] = '{8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 10'd28, 8'h5D, 16'd1, 1'b1};
    vecs[13] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 10'd4,  8'h57, 16'd2, 1'b1};
    vecs[14] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 10'd4,  8'h57, 16'd2, 1'b0};

    for (int v = 0; v < NV; v++) begin
      bus.hw_mem_wr = vecs[v].req;
      hold          = vecs[v].hold;
      cnt_clr       = vecs[v].clr;
      tick();
      check($sformatf("vec%0d_ack", v), 32'(bus.hw_mem_wr_ack_p), 32'(vecs[v].ack));
      check($sformatf("vec%0d_we", v), 32'(bus.act_mem_we), 32'(vecs[v].we));
      check($sformatf("vec%0d_addr", v), 32'(bus.act_mem_addr), 32'(vecs[v].addr));
      check($sformatf("vec%0d_wdata", v), 32'(bus.act_mem_wdata), 32'(vecs[v].wdata));
      check($sformatf("vec%0d_cnt", v), 32'(wr_count), 32'(vecs[v].cnt));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
      check($sformatf("vec%0d_rerr", v), 32'(range_err), 32'h0);
    end
    bus.hw_mem_wr = '0;
    hold          = 1'b0;
    cnt_clr       = 1'b0;

    // All eight request at once from rr_ptr=0: grants 0..7 on cycles 1,3,..,15
    begin
      int grants;
      int cyc;
      int ack_cnt [NN];
      do_reset();
      for (int i = 0; i < NN; i++) ack_cnt[i] = 0;
      grants        = 0;
      cyc           = 0;
      bus.hw_mem_wr = 8'hFF;
      while (grants < NN && cyc < 40) begin
        tick();
        cyc++;
        if (bus.act_mem_we) mem[bus.act_mem_addr] = bus.act_mem_wdata;
        if (bus.hw_mem_wr_ack_p != '0) begin
          check($sformatf("all_onehot%0d", grants), 32'($countones(bus.hw_mem_wr_ack_p)), 32'd1);
          check($sformatf("all_order%0d", grants), 32'(bus.hw_mem_wr_ack_p), 32'(1) << grants);
          check($sformatf("all_cycle%0d", grants), 32'(cyc), 32'(2 * grants + 1));
          for (int i = 0; i < NN; i++) if (bus.hw_mem_wr_ack_p[i]) ack_cnt[i]++;
          bus.hw_mem_wr = bus.hw_mem_wr & ~bus.hw_mem_wr_ack_p;
          grants++;
        end
      end
      check("all_grants", 32'(grants), 32'(NN));
      tick();
      check("all_no_extra_ack", 32'(bus.hw_mem_wr_ack_p), 32'h0);
      check("all_cnt", 32'(wr_count), 32'd8);
      for (int i = 0; i < NN; i++) begin
        check($sformatf("all_acks_n%0d", i), 32'(ack_cnt[i]), 32'd1);
        check($sformatf("all_mem_n%0d", i), 32'(mem[i * 4 + 4]), 32'(8'h57 + i));
      end
    end

    // Neurons 2 and 5 re-request after every ack: grants alternate 2,5,2,5,..
    begin
      int grants;
      int cyc;
      int exp_idx [6];
      exp_idx = '{2, 5, 2, 5, 2, 5};
      do_reset();
      grants        = 0;
      cyc           = 0;
      bus.hw_mem_wr = 8'h24;
      while (grants < 6 && cyc < 40) begin
        tick();
        cyc++;
        if (bus.hw_mem_wr_ack_p != '0) begin
          check($sformatf("fair_grant%0d", grants), 32'(bus.hw_mem_wr_ack_p),
                32'(1) << exp_idx[grants]);
          grants++;
        end
        bus.hw_mem_wr = 8'h24 & ~bus.hw_mem_wr_ack_p;
      end
      check("fair_grants", 32'(grants), 32'd6);
      bus.hw_mem_wr = '0;
      tick();
      tick();
    end

    // hold for 10 cycles with neurons 0 and 1 pending, then release
    begin
      int bad;
      do_reset();
      hold          = 1'b1;
      bus.hw_mem_wr = 8'h03;
      bad           = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (bus.act_mem_we !== 1'b0 || bus.hw_mem_wr_ack_p !== '0 || busy !== 1'b1) bad++;
      end
      check("hold_quiet_cycles", 32'(bad), 32'd0);
      check("hold_cnt", 32'(wr_count), 32'd0);
      hold = 1'b0;
      tick();
      check("hold_rel_ack0", 32'(bus.hw_mem_wr_ack_p), 32'h01);
      check("hold_rel_we0", 32'(bus.act_mem_we), 32'h1);
      bus.hw_mem_wr = 8'h02;
      tick();
      check("hold_rel_gap", 32'(bus.hw_mem_wr_ack_p), 32'h00);
      tick();
      check("hold_rel_ack1", 32'(bus.hw_mem_wr_ack_p), 32'h02);
      check("hold_rel_addr1", 32'(bus.act_mem_addr), 32'd8);
      bus.hw_mem_wr = '0;
      tick();
    end

    // Range error: neuron 1 writes in range, then neuron 0 at addr 120
    begin
      do_reset();
      bus.hw_mem_wr_addr[0 +: AW] = 10'd120;
      bus.hw_mem_wr = 8'h02;
      tick();
      check("rng_ok_we", 32'(bus.act_mem_we), 32'h1);
      check("rng_ok_cnt", 32'(wr_count), 32'd1);
      bus.hw_mem_wr = 8'h00;
      tick();
      bus.hw_mem_wr = 8'h01;
      tick();
      check("rng_ack", 32'(bus.hw_mem_wr_ack_p), 32'h01);
      check("rng_we", 32'(bus.act_mem_we), 32'h0);
      check("rng_err", 32'(range_err), 32'h1);
      check("rng_cnt", 32'(wr_count), 32'd1);
      bus.hw_mem_wr = 8'h00;
      tick();
      check("rng_sticky", 32'(range_err), 32'h1);
      check("rng_ack_gone", 32'(bus.hw_mem_wr_ack_p), 32'h00);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("rng_clr_err", 32'(range_err), 32'h0);
      check("rng_clr_cnt", 32'(wr_count), 32'd0);
      set_neuron_payloads();
    end

    // Reset asserted during WRITE
    begin
      int bad;
      bus.hw_mem_wr = 8'h10;
      tick();
      check("rstw_pre_ack", 32'(bus.hw_mem_wr_ack_p), 32'h10);
      check("rstw_pre_cnt", 32'(wr_count), 32'd1);
      #2;
      rst           = 1'b0;
      bus.hw_mem_wr = '0;
      #1;
      check("rstw_ack", 32'(bus.hw_mem_wr_ack_p), 32'h0);
      check("rstw_we", 32'(bus.act_mem_we), 32'h0);
      check("rstw_addr", 32'(bus.act_mem_addr), 32'h0);
      check("rstw_wdata", 32'(bus.act_mem_wdata), 32'h0);
      check("rstw_cnt", 32'(wr_count), 32'h0);
      check("rstw_busy", 32'(busy), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (bus.hw_mem_wr_ack_p !== '0 || bus.act_mem_we !== 1'b0) bad++;
      end
      check("rstw_no_ack_after", 32'(bad), 32'd0);
      bus.hw_mem_wr = 8'h10;
      tick();
      check("rstw_fresh_ack", 32'(bus.hw_mem_wr_ack_p), 32'h10);
      check("rstw_fresh_addr", 32'(bus.act_mem_addr), 32'd20);
      bus.hw_mem_wr = '0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
